// File: rtl/morse_decoder.sv
// morse_decoder: samples a synchronised Morse key on a slow tick, times presses as dots/dashes
// and decodes up to four symbols into the 3-bit letter code for Q..X.
module morse_decoder #(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int DASH_TICKS  = 3,
    parameter int GAP_TICKS   = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_N,
    output logic [2:0] LETTER,
    output logic       VALID,
    output logic       ERROR,
    output logic       TONE,
    output logic [2:0] SYM_CNT
);
    localparam int TW = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, DECODE} state_t;

    state_t         state, state_n;
    logic           key_s1, key_s2;
    logic [TW-1:0]  tick_cnt;
    logic           tick, pressed, sym, hit, ok;
    logic [7:0]     press_cnt, press_n, gap_cnt, gap_n;
    logic [3:0]     pat, pat_n;
    logic [2:0]     len, len_n, code;
    logic           ovf, ovf_n;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= KEY_N;
            key_s2 <= key_s1;
        end
    end

    assign pressed = ~key_s2;
    assign TONE    = pressed;
    assign SYM_CNT = len;
    assign tick    = tick_cnt == TW'(TICK_CYCLES - 1);
    assign sym     = press_cnt >= 8'(DASH_TICKS);
    assign ok      = hit & ~ovf;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) tick_cnt <= '0;
        else       tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    // pat is right-justified and zero-filled above len, so {len, pat} is a unique code word
    always_comb begin
        hit  = 1'b1;
        code = 3'd0;
        case ({len, pat})
            7'b100_1101: code = 3'd0;
            7'b011_0010: code = 3'd1;
            7'b011_0000: code = 3'd2;
            7'b001_0001: code = 3'd3;
            7'b011_0001: code = 3'd4;
            7'b100_0001: code = 3'd5;
            7'b011_0011: code = 3'd6;
            7'b100_1001: code = 3'd7;
            default:     hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        press_n = press_cnt;
        gap_n   = gap_cnt;
        pat_n   = pat;
        len_n   = len;
        ovf_n   = ovf;
        case (state)
            IDLE: if (tick && pressed) begin
                state_n = PRESS;
                press_n = 8'd1;
            end
            PRESS: if (tick) begin
                if (pressed) begin
                    press_n = (press_cnt == 8'hff) ? press_cnt : press_cnt + 8'd1;
                end else begin
                    state_n = GAP;
                    gap_n   = 8'd1;
                    if (len < 3'd4) begin
                        pat_n = {pat[2:0], sym};
                        len_n = len + 3'd1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            GAP: if (tick) begin
                if (pressed) begin
                    state_n = PRESS;
                    press_n = 8'd1;
                end else if (gap_cnt == 8'(GAP_TICKS - 1)) begin
                    state_n = DECODE;
                end else begin
                    gap_n = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                pat_n   = 4'd0;
                len_n   = 3'd0;
                ovf_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            press_cnt <= 8'd0;
            gap_cnt   <= 8'd0;
            pat       <= 4'd0;
            len       <= 3'd0;
            ovf       <= 1'b0;
            LETTER    <= 3'd0;
            VALID     <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            state     <= state_n;
            press_cnt <= press_n;
            gap_cnt   <= gap_n;
            pat       <= pat_n;
            len       <= len_n;
            ovf       <= ovf_n;
            VALID     <= (state == DECODE) && ok;
            if ((state == DECODE) && ok) LETTER <= code;
            if (state == DECODE) ERROR <= ~ok;
        end
    end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: keys letters with random press/gap lengths and checks the decoder
// against a string-based Morse model.
module tb_morse_decoder;
    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b0;
    logic       KEY_N = 1'b1;
    logic [2:0] LETTER, SYM_CNT;
    logic       VALID, ERROR, TONE;

    int vectors = 0, miscompares = 0;
    int vcnt = 0, exp_v = 0;
    int exp_letter = 0, exp_err = 0;
    logic [2:0] last_letter = 3'd0;
    int durs[$];
    string morse [8] = '{"--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-"};

    morse_decoder #(.TICK_CYCLES(4), .DASH_TICKS(3), .GAP_TICKS(4)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N),
        .LETTER(LETTER), .VALID(VALID), .ERROR(ERROR), .TONE(TONE), .SYM_CNT(SYM_CNT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (VALID === 1'b1) begin
            vcnt++;
            last_letter = LETTER;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int lookup(input string s);
        for (int i = 0; i < 8; i++) if (s == morse[i]) return i;
        return -1;
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic key_for(input bit down, input int ticks);
        KEY_N = ~down;
        clocks(4 * ticks);
    endtask

    // Key released: let the letter end, then compare against the model.
    task automatic finish_letter(input string s);
        int idx;
        KEY_N = 1'b1;
        clocks(8);
        check("sym_cnt_letter", SYM_CNT, (s.len() > 4) ? 4 : s.len());
        clocks(24);
        idx = lookup(s);
        if (idx >= 0) begin
            exp_letter = idx;
            exp_err = 0;
            exp_v++;
            check("valid_letter", last_letter, idx);
        end else begin
            exp_err = 1;
        end
        check("valid_count", vcnt, exp_v);
        check("letter", LETTER, exp_letter);
        check("error", ERROR, exp_err);
        check("sym_cnt_idle", SYM_CNT, 0);
    endtask

    task automatic play_durs();
        string s = "";
        for (int i = 0; i < durs.size(); i++) begin
            key_for(1'b1, durs[i]);
            s = {s, (durs[i] >= 3) ? "-" : "."};
            if (i < durs.size() - 1) key_for(1'b0, $urandom_range(1, 3));
        end
        finish_letter(s);
    endtask

    task automatic play_code(input string c);
        durs.delete();
        for (int i = 0; i < c.len(); i++)
            durs.push_back((c[i] == "-") ? $urandom_range(3, 6) : $urandom_range(1, 2));
        play_durs();
    endtask

    initial begin
        #2 RESET = 1'b1;
        #1;
        check("rst_letter", LETTER, 0);
        check("rst_valid", VALID, 0);
        check("rst_error", ERROR, 0);
        check("rst_tone", TONE, 0);
        check("rst_sym_cnt", SYM_CNT, 0);
        clocks(2);
        RESET = 1'b0;
        clocks(100);
        check("idle_no_valid", vcnt, 0);
        check("idle_error", ERROR, 0);

        // T with TONE latency probe
        KEY_N = 1'b0;
        clocks(1);
        check("tone_lat1", TONE, 0);
        clocks(1);
        check("tone_lat2", TONE, 1);
        clocks(10);
        finish_letter("-");

        // Q with exact lengths, then the 2-tick dot boundary via S
        durs = '{3, 3, 1, 3};
        play_durs();
        durs = '{2, 2, 2};
        play_durs();
        // saturating long press stays a dash
        durs = '{300};
        play_durs();

        for (int k = 0; k < 8; k++) play_code(morse[k]);

        play_code(".....");
        play_code(".-");
        play_code("...");

        // reset mid-letter while key is held
        key_for(1'b1, 1);
        key_for(1'b0, 1);
        key_for(1'b1, 1);
        KEY_N = 1'b1;
        clocks(8);
        check("mid_sym_cnt", SYM_CNT, 2);
        KEY_N = 1'b0;
        clocks(3);
        #3 RESET = 1'b1;
        #1;
        exp_letter = 0;
        exp_err = 0;
        check("mid_rst_sym_cnt", SYM_CNT, 0);
        check("mid_rst_tone", TONE, 0);
        check("mid_rst_letter", LETTER, 0);
        clocks(2);
        RESET = 1'b0;
        KEY_N = 1'b1;
        clocks(30);
        check("mid_rst_no_valid", vcnt, exp_v);
        play_code("..-");

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                play_code(morse[$urandom_range(0, 7)]);
            end else begin
                durs.delete();
                for (int i = 0; i < $urandom_range(1, 5); i++) durs.push_back($urandom_range(1, 5));
                play_durs();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
